// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over the shared data bus, stalling until DONE.
// Optional alignment trap under MEM_ALIGN_CHECK_EN (misaligned LH/LHU/SH/LW/SW skip the bus).
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        stallreq_o,
  input  logic        bus_gnt_i,
  output logic [31:0] mem_a_o,
  output logic [7:0]  mem_dout_o,
  output logic        mem_wr_o,
  output logic        mem_req_o,
  input  logic [7:0]  mem_din_i,
  output logic        misalign_o
);
  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_buf;
  logic        r_pend;
  logic [1:0]  r_idx;
  logic        w_is_load, w_is_store, w_is_mem, w_issue, w_last;
  logic [2:0]  w_nbytes;
  logic [31:0] w_ldata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        r_mis;
  logic        w_misalign;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_buf   <= 32'd0;
      r_pend  <= 1'b0;
      r_idx   <= 2'd0;
`ifdef MEM_ALIGN_CHECK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_cnt <= 3'd0;
      else if (w_issue)      r_cnt <= r_cnt + 3'd1;
      // read data returns one cycle after its address, so remember which byte is in flight
      r_pend <= w_issue && w_is_load;
      if (w_issue) r_idx <= r_cnt[1:0];
      if (r_state == S_IDLE && w_is_mem) r_buf <= 32'd0;
      else if (r_pend)                   r_buf[{r_idx, 3'b000} +: 8] <= mem_din_i;
`ifdef MEM_ALIGN_CHECK_EN
      r_mis <= (r_state == S_IDLE) && w_misalign;
`endif
    end
  end

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_nbytes   = 3'd1;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: w_is_load = 1'b1;
      EXE_LH_OP, EXE_LHU_OP: begin w_is_load = 1'b1; w_nbytes = 3'd2; end
      EXE_LW_OP:             begin w_is_load = 1'b1; w_nbytes = 3'd4; end
      EXE_SB_OP:             w_is_store = 1'b1;
      EXE_SH_OP:             begin w_is_store = 1'b1; w_nbytes = 3'd2; end
      EXE_SW_OP:             begin w_is_store = 1'b1; w_nbytes = 3'd4; end
      default: ;
    endcase
    w_is_mem = w_is_load || w_is_store;
    w_last   = (r_cnt == w_nbytes - 3'd1);
`ifdef MEM_ALIGN_CHECK_EN
    w_misalign = w_is_mem && ((w_nbytes == 3'd2 && mem_addr_i[0]) ||
                              (w_nbytes == 3'd4 && mem_addr_i[1:0] != 2'b00));
`endif

    w_ldata = r_buf;
    case (aluop_i)
      EXE_LB_OP:  w_ldata = {{24{r_buf[7]}}, r_buf[7:0]};
      EXE_LBU_OP: w_ldata = {24'd0, r_buf[7:0]};
      EXE_LH_OP:  w_ldata = {{16{r_buf[15]}}, r_buf[15:0]};
      EXE_LHU_OP: w_ldata = {16'd0, r_buf[15:0]};
      default: ;
    endcase

    w_issue     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          w_state_nxt = S_ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          if (w_misalign) w_state_nxt = S_DONE;
`endif
        end
      end
      S_ACCESS: begin
        if (bus_gnt_i) begin
          w_issue = 1'b1;
          if (w_last) w_state_nxt = w_is_store ? S_DONE : S_WAIT;
        end
      end
      S_WAIT:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    misalign_o = 1'b0;
    mem_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    mem_a_o    = 32'd0;
    mem_dout_o = 8'd0;
    if (w_is_mem) begin
      stallreq_o = (r_state != S_DONE);
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      if (r_state == S_DONE) begin
        wreg_o  = w_is_load ? wreg_i : 1'b0;
        wdata_o = w_is_load ? w_ldata : 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
        if (r_mis) begin
          wreg_o     = 1'b0;
          misalign_o = 1'b1;
        end
`endif
      end
    end
    // the request stays up while waiting for a grant so the arbiter sees us
    if (r_state == S_ACCESS) begin
      mem_req_o  = 1'b1;
      mem_a_o    = mem_addr_i + {29'd0, r_cnt};
      mem_wr_o   = w_is_store;
      mem_dout_o = w_is_store ? reg2_i[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
    end
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      stallreq_o = 1'b0;
      misalign_o = 1'b0;
      mem_req_o  = 1'b0;
      mem_wr_o   = 1'b0;
      mem_a_o    = 32'd0;
      mem_dout_o = 8'd0;
    end
  end

  assign mem_wd_o    = wd_o;
  assign mem_wreg_o  = wreg_o;
  assign mem_wdata_o = wdata_o;
endmodule
